// File: rtl/game_pkg.sv
// Shared types and constants for the reaction game's input stage.
// Holds the button FSM state encoding and the glitch-counter width/limit,
// plus a small saturating-increment helper for that counter.
package game_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      RELEASE_WAIT
   } btn_state_t;

   localparam int                     BOUNCE_CNT_W   = 8;
   localparam logic [BOUNCE_CNT_W-1:0] BOUNCE_CNT_MAX = 8'hFF;

   // Adds one unless the counter already sits at its ceiling, so the
   // diagnostic count sticks at the maximum instead of wrapping to zero.
   function automatic logic [BOUNCE_CNT_W-1:0] bounceSatInc(
      input logic [BOUNCE_CNT_W-1:0] value
   );
      logic [BOUNCE_CNT_W-1:0] result;
      if (value == BOUNCE_CNT_MAX) begin
         result = value;
      end else begin
         result = value + 1'b1;
      end
      return result;
   endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Signal bundle between the raw push-button pin and the score logic.
// master: the side that owns the pin and consumes the conditioned outputs.
// slave:  the conditioner itself, which reads the pin and drives the outputs.
interface button_conditioner_if;
   import game_pkg::*;

   logic                    button_raw;
   logic                    btn_level;
   logic                    btn_press_pulse;
   logic                    btn_release_pulse;
   logic [BOUNCE_CNT_W-1:0] bounce_cnt;

   modport master (
      output button_raw,
      input  btn_level,
      input  btn_press_pulse,
      input  btn_release_pulse,
      input  bounce_cnt
   );

   modport slave (
      input  button_raw,
      output btn_level,
      output btn_press_pulse,
      output btn_release_pulse,
      output bounce_cnt
   );

endinterface

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for pins that are asynchronous to clk.
// The reset value is a parameter so the chain can power up at whatever
// level means "inactive" for the pin it guards.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   // First flop may go metastable; the second gives it a full cycle to settle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner feeding the reaction game's score path.
// Synchronises the raw pin, normalises its polarity so 1 means pressed,
// and debounces it with a four-state FSM that emits a registered level
// plus one-cycle press/release strobes. Rejected glitches are tallied in
// a saturating diagnostic counter.
// Optional feature: define BUTTON_AUTOREPEAT_EN to make a long hold re-fire
// the press strobe (after REPEAT_DELAY cycles, then every REPEAT_RATE cycles).
// REPEAT_RATE must be at least 2 and no larger than REPEAT_DELAY.
module button_conditioner
   import game_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 16,
   parameter int ACTIVE_LOW      = 1
`ifdef BUTTON_AUTOREPEAT_EN
   ,
   parameter int REPEAT_DELAY    = 64,
   parameter int REPEAT_RATE     = 16
`endif
) (
   input  logic                 clk,
   input  logic                 reset,
   button_conditioner_if.slave  btn
);

   // Pin level that means "not pressed"; the synchroniser powers up here.
   localparam logic             PIN_IDLE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
   // Counter value at which a new level has been stable long enough.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic                    w_pinSync;
   logic                    w_s;

   btn_state_t              r_state;
   logic [CNT_W-1:0]        r_cnt;
   logic                    r_level;
   logic                    r_press;
   logic                    r_release;
   logic [BOUNCE_CNT_W-1:0] r_bounce;

   btn_state_t              w_stateNext;
   logic [CNT_W-1:0]        w_cntNext;
   logic [CNT_W-1:0]        w_cntInc;
   logic                    w_levelNext;
   logic                    w_pressNext;
   logic                    w_releaseNext;
   logic [BOUNCE_CNT_W-1:0] w_bounceNext;

   sync_2ff #(
      .RESET_VAL (PIN_IDLE)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .i_d   (btn.button_raw),
      .o_q   (w_pinSync)
   );

   assign w_s      = (ACTIVE_LOW != 0) ? ~w_pinSync : w_pinSync;
   assign w_cntInc = r_cnt + 1'b1;

`ifdef BUTTON_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] REP_FIRST  = CNT_W'(REPEAT_DELAY);
   localparam logic [CNT_W-1:0] REP_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_RATE);

   logic [CNT_W-1:0] r_rep;
   logic [CNT_W-1:0] w_repNext;
   logic [CNT_W-1:0] w_repInc;
   logic             w_repFire;

   assign w_repInc  = r_rep + 1'b1;
   assign w_repFire = (r_state == HELD) && w_s && (w_repInc == REP_FIRST);

   // Count cycles spent in HELD; after each repeat strobe, rewind so the
   // next one lands REPEAT_RATE cycles later. Any exit from HELD clears it.
   always_comb begin
      w_repNext = '0;
      if ((r_state == HELD) && w_s) begin
         w_repNext = w_repFire ? REP_RELOAD : w_repInc;
      end
   end

   // Repeat-timer register, cleared on reset like every other flop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rep <= '0;
      end else begin
         r_rep <= w_repNext;
      end
   end
`endif

   // Next-state logic: a level change is only accepted after DEBOUNCE_CYCLES
   // consecutive agreeing samples; an early flip back counts as a glitch.
   always_comb begin
      w_stateNext   = r_state;
      w_cntNext     = r_cnt;
      w_levelNext   = r_level;
      w_pressNext   = 1'b0;
      w_releaseNext = 1'b0;
      w_bounceNext  = r_bounce;

      case (r_state)
         IDLE: begin
            w_levelNext = 1'b0;
            if (w_s) begin
               w_stateNext = PRESS_WAIT;
               w_cntNext   = '0;
            end
         end

         PRESS_WAIT: begin
            if (w_s) begin
               w_cntNext = w_cntInc;
               if (w_cntInc == CNT_LAST) begin
                  w_stateNext = HELD;
                  w_levelNext = 1'b1;
                  w_pressNext = 1'b1;
               end
            end else begin
               w_stateNext  = IDLE;
               w_bounceNext = bounceSatInc(r_bounce);
            end
         end

         HELD: begin
            w_levelNext = 1'b1;
            if (!w_s) begin
               w_stateNext = RELEASE_WAIT;
               w_cntNext   = '0;
            end else begin
`ifdef BUTTON_AUTOREPEAT_EN
               w_pressNext = w_repFire;
`endif
            end
         end

         RELEASE_WAIT: begin
            if (!w_s) begin
               w_cntNext = w_cntInc;
               if (w_cntInc == CNT_LAST) begin
                  w_stateNext   = IDLE;
                  w_levelNext   = 1'b0;
                  w_releaseNext = 1'b1;
               end
            end else begin
               w_stateNext  = HELD;
               w_bounceNext = bounceSatInc(r_bounce);
            end
         end

         default: begin
            w_stateNext = IDLE;
            w_cntNext   = '0;
            w_levelNext = 1'b0;
         end
      endcase
   end

   // State, counter and registered outputs; reset drops everything at once,
   // which also discards any press in progress without a release strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_level   <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_bounce  <= '0;
      end else begin
         r_state   <= w_stateNext;
         r_cnt     <= w_cntNext;
         r_level   <= w_levelNext;
         r_press   <= w_pressNext;
         r_release <= w_releaseNext;
         r_bounce  <= w_bounceNext;
      end
   end

   assign btn.btn_level         = r_level;
   assign btn.btn_press_pulse   = r_press;
   assign btn.btn_release_pulse = r_release;
   assign btn.bounce_cnt        = r_bounce;

endmodule
